// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target with address match, register pointer and byte memory.
// Optional SCL clock stretching after every ACK/NACK slot when I2C_SLV_STRETCH_EN is defined.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h51,
    parameter int         MEM_DEPTH      = 16,
    parameter int         SYNC_STAGES    = 2,
    parameter int         STRETCH_CYCLES = 8
) (
    input  logic       CLK_I,
    input  logic       RESET,
    input  logic       SCL_PAD_I,
    input  logic       SDA_PAD_I,
    output logic       SCL_PAD_O,
    output logic       SCL_PADOEN_O,
    output logic       SDA_PAD_O,
    output logic       SDA_PADOEN_O,
    output logic       BUSY_O,
    output logic       WR_STB_O,
    output logic [7:0] WR_ADDR_O,
    output logic [7:0] WR_DATA_O
);

    localparam int PW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_ADDR_ACK = 4'd2;
    localparam logic [3:0] S_PTR      = 4'd3;
    localparam logic [3:0] S_PTR_ACK  = 4'd4;
    localparam logic [3:0] S_WR_DATA  = 4'd5;
    localparam logic [3:0] S_WR_ACK   = 4'd6;
    localparam logic [3:0] S_RD_DATA  = 4'd7;
    localparam logic [3:0] S_RD_ACK   = 4'd8;
    localparam logic [3:0] S_WAIT     = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [3:0]    state;
    logic [2:0]    bit_cnt;
    logic          got_byte;
    logic          rd_mode;
    logic          mst_ack;
    logic [7:0]    rx_sh;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_inc;
    logic [7:0]    mem [MEM_DEPTH];
    logic          sda_oen;
    logic          busy;
    logic          wr_stb;
    logic [7:0]    wr_addr;
    logic [7:0]    wr_data;

    always_ff @(posedge CLK_I) begin
        if (RESET) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_PAD_I};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_PAD_I};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    // Byte being completed on this rise, and the byte the read path serves next.
    assign rx_byte = {rx_sh[6:0], sda_s};
    assign rd_byte = mem[ptr];
    assign ptr_inc = ptr + 1'b1;

    always_ff @(posedge CLK_I) begin
        if (RESET) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd0;
            got_byte <= 1'b0;
            rd_mode  <= 1'b0;
            mst_ack  <= 1'b0;
            rx_sh    <= 8'h00;
            tx_sh    <= 8'h00;
            ptr      <= '0;
            sda_oen  <= 1'b1;
            busy     <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            wr_stb <= 1'b0;
            if (start_det) begin
                state    <= S_ADDR;
                bit_cnt  <= 3'd0;
                got_byte <= 1'b0;
                sda_oen  <= 1'b1;
                busy     <= 1'b1;
            end else if (stop_det) begin
                state    <= S_IDLE;
                bit_cnt  <= 3'd0;
                got_byte <= 1'b0;
                sda_oen  <= 1'b1;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_PTR, S_WR_DATA: begin
                        if (scl_rise && !got_byte) begin
                            rx_sh   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                got_byte <= 1'b1;
                                if (state == S_PTR) begin
                                    ptr <= rx_byte[PW-1:0];
                                end
                                if (state == S_WR_DATA) begin
                                    mem[ptr] <= rx_byte;
                                    wr_stb   <= 1'b1;
                                    wr_addr  <= 8'(ptr);
                                    wr_data  <= rx_byte;
                                    ptr      <= ptr_inc;
                                end
                            end
                        end else if (scl_fall && got_byte) begin
                            got_byte <= 1'b0;
                            bit_cnt  <= 3'd0;
                            if (state == S_ADDR) begin
                                if (rx_sh[7:1] == SLAVE_ADDR) begin
                                    state   <= S_ADDR_ACK;
                                    sda_oen <= 1'b0;
                                    rd_mode <= rx_sh[0];
                                end else begin
                                    state <= S_WAIT;
                                end
                            end else if (state == S_PTR) begin
                                state   <= S_PTR_ACK;
                                sda_oen <= 1'b0;
                            end else begin
                                state   <= S_WR_ACK;
                                sda_oen <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rd_mode) begin
                                state   <= S_RD_DATA;
                                tx_sh   <= rd_byte;
                                sda_oen <= rd_byte[7];
                            end else begin
                                state   <= S_PTR;
                                sda_oen <= 1'b1;
                            end
                        end
                    end
                    S_PTR_ACK, S_WR_ACK: begin
                        if (scl_fall) begin
                            state   <= S_WR_DATA;
                            sda_oen <= 1'b1;
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_rise && !got_byte) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                got_byte <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (got_byte) begin
                                state    <= S_RD_ACK;
                                got_byte <= 1'b0;
                                bit_cnt  <= 3'd0;
                                sda_oen  <= 1'b1;
                                ptr      <= ptr_inc;
                            end else begin
                                tx_sh   <= {tx_sh[6:0], 1'b0};
                                sda_oen <= tx_sh[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            mst_ack <= ~sda_s;
                        end else if (scl_fall) begin
                            if (mst_ack) begin
                                state   <= S_RD_DATA;
                                tx_sh   <= rd_byte;
                                sda_oen <= rd_byte[7];
                            end else begin
                                state   <= S_WAIT;
                                sda_oen <= 1'b1;
                            end
                        end
                    end
                    S_IDLE, S_WAIT: begin
                        sda_oen <= 1'b1;
                    end
                    default: begin
                        state   <= S_IDLE;
                        sda_oen <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef I2C_SLV_STRETCH_EN
    localparam int CW = $clog2(STRETCH_CYCLES + 1);

    logic          ack_fall;
    logic          scl_oen;
    logic [CW-1:0] st_cnt;

    // Falling SCL that closes any ACK/NACK slot, slave- or master-driven.
    assign ack_fall = scl_fall && !start_det && !stop_det &&
                      (state == S_ADDR_ACK || state == S_PTR_ACK ||
                       state == S_WR_ACK   || state == S_RD_ACK);

    always_ff @(posedge CLK_I) begin
        if (RESET) begin
            scl_oen <= 1'b1;
            st_cnt  <= '0;
        end else if (ack_fall) begin
            scl_oen <= 1'b0;
            st_cnt  <= CW'(STRETCH_CYCLES - 1);
        end else if (!scl_oen) begin
            if (st_cnt == '0) begin
                scl_oen <= 1'b1;
            end else begin
                st_cnt <= st_cnt - 1'b1;
            end
        end
    end

    assign SCL_PADOEN_O = scl_oen;
`else
    assign SCL_PADOEN_O = 1'b1;
`endif

    assign SCL_PAD_O    = 1'b0;
    assign SDA_PAD_O    = 1'b0;
    assign SDA_PADOEN_O = sda_oen;
    assign BUSY_O       = busy;
    assign WR_STB_O     = wr_stb;
    assign WR_ADDR_O    = wr_addr;
    assign WR_DATA_O    = wr_data;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb/tb_i2c_slave_responder.sv - bit-banged I2C master with transaction-level reference model.
module tb_i2c_slave_responder;

    localparam int         DEPTH = 16;
    localparam logic [6:0] ADDR  = 7'h51;
    localparam int         Q     = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_o, scl_oen, sda_o, sda_oen, busy, wr_stb;
    logic [7:0] wr_addr, wr_data;
    logic scl_bus, sda_bus;

    assign scl_bus = scl_m & (scl_oen | scl_o);
    assign sda_bus = sda_m & (sda_oen | sda_o);

    always #5 clk = ~clk;

    i2c_slave_responder #(
        .SLAVE_ADDR(ADDR), .MEM_DEPTH(DEPTH), .SYNC_STAGES(2), .STRETCH_CYCLES(8)
    ) dut (
        .CLK_I(clk), .RESET(rst), .SCL_PAD_I(scl_bus), .SDA_PAD_I(sda_bus),
        .SCL_PAD_O(scl_o), .SCL_PADOEN_O(scl_oen), .SDA_PAD_O(sda_o), .SDA_PADOEN_O(sda_oen),
        .BUSY_O(busy), .WR_STB_O(wr_stb), .WR_ADDR_O(wr_addr), .WR_DATA_O(wr_data)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] bq[$];
    logic [7:0] ref_mem[DEPTH];
    int         ref_ptr;
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && wr_stb) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got idx %0d data %02h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_wr.pop_front();
                check("wr_idx", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

`ifdef I2C_SLV_STRETCH_EN
    int st_len = 0;
    always @(negedge clk) begin
        if (!rst && !scl_oen) begin
            st_len++;
        end else if (st_len != 0) begin
            if (!rst) check("stretch_len", 32'(st_len), 32'd8);
            st_len = 0;
        end
    end
`endif

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raise_scl();
        int t = 0;
        scl_m = 1'b1;
        while (!scl_bus && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!scl_bus) begin
            n_checks++;
            n_fail++;
            $display("FAIL scl_release: SCL low after %0d cycles, required high", t);
        end
        wait_clk(Q);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b;
        wait_clk(Q);
        raise_scl();
        s = sda_bus;
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q);
        raise_scl();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        raise_scl();
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(v[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] v);
        logic s;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, s);
            v = {v[6:0], s};
        end
        bit_cycle(~mack, s);
    endtask

    // Write transaction of bq (pointer first); model applies the target's rules directly.
    task automatic do_write(input logic [6:0] a, input bit do_stop);
        logic ack;
        bit   match = (a == ADDR);
        i2c_start();
        check("busy_after_start", 32'(busy), 32'd1);
        write_byte({a, 1'b0}, ack);
        check("addr_ack_w", 32'(ack), 32'(match));
        for (int i = 0; i < bq.size(); i++) begin
            if (match) begin
                if (i == 0) begin
                    ref_ptr = int'(bq[0]) % DEPTH;
                end else begin
                    exp_wr.push_back({8'(ref_ptr), bq[i]});
                    ref_mem[ref_ptr] = bq[i];
                    ref_ptr = (ref_ptr + 1) % DEPTH;
                end
            end
            write_byte(bq[i], ack);
            check("data_ack", 32'(ack), 32'(match));
        end
        if (do_stop) begin
            i2c_stop();
            check("busy_after_stop", 32'(busy), 32'd0);
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        logic       ack;
        logic [7:0] got;
        logic [7:0] exp;
        bit         match = (a == ADDR);
        i2c_start();
        write_byte({a, 1'b1}, ack);
        check("addr_ack_r", 32'(ack), 32'(match));
        if (match) begin
            for (int i = 0; i < n; i++) begin
                exp = ref_mem[ref_ptr];
                ref_ptr = (ref_ptr + 1) % DEPTH;
                read_byte(i < n - 1, got);
                check("rd_data", 32'(got), 32'(exp));
            end
            check("sda_released_after_nack", 32'(sda_oen), 32'd1);
        end
        i2c_stop();
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic partial_bits(input int n);
        logic s;
        for (int i = 0; i < n; i++) bit_cycle(1'($urandom_range(0, 1)), s);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        ref_ptr = 0;
    endtask

    initial begin
        logic       ack;
        logic [6:0] a;
        int         n;
        model_reset();
        wait_clk(4);
        check("rst_sda_oen", 32'(sda_oen), 32'd1);
        check("rst_scl_oen", 32'(scl_oen), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        wait_clk(4);

        bq = '{8'h03, 8'h5A, 8'hC3};
        do_write(ADDR, 1'b1);

        bq = '{8'h03};
        do_write(ADDR, 1'b0);
        do_read(ADDR, 2);

        bq = '{8'h03, 8'h5A};
        do_write(7'h48, 1'b1);

        bq = '{8'h0F, 8'h11, 8'h22};
        do_write(ADDR, 1'b1);
        do_read(ADDR, 1);

        // Partial bytes cut by STOP and by repeated START must not write.
        bq = '{8'h05};
        do_write(ADDR, 1'b0);
        partial_bits(4);
        i2c_stop();
        do_read(ADDR, 1);
        bq = '{8'h09};
        do_write(ADDR, 1'b0);
        partial_bits(6);
        do_read(ADDR, 1);

        // Reset while the target drives a 0 data bit.
        i2c_start();
        write_byte({ADDR, 1'b1}, ack);
        check("rst_test_ack", 32'(ack), 32'd1);
        sda_m = 1'b1;
        wait_clk(Q);
        check("rd_drive_low", 32'(sda_oen), 32'(ref_mem[ref_ptr][7]));
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        check("midrst_sda_oen", 32'(sda_oen), 32'd1);
        check("midrst_scl_oen", 32'(scl_oen), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        i2c_stop();
        do_read(ADDR, DEPTH);

        for (int k = 0; k < 20; k++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
            if (a != ADDR && a[6:1] == ADDR[6:1]) a = 7'h22;
            case ($urandom_range(0, 2))
                0: begin
                    n = $urandom_range(1, 4);
                    bq = {};
                    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
                    do_write(a, 1'b1);
                end
                1: do_read(a, $urandom_range(1, 3));
                default: begin
                    bq = '{8'($urandom)};
                    do_write(a, 1'b0);
                    do_read(a, $urandom_range(1, 3));
                end
            endcase
        end

        wait_clk(20);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
